msdap_piso_nch: RTL and testbench
=================================

# msdap_piso_nch

Parametrised, double-buffered parallel-to-serial converter for the MSDAP output path. It accepts one packed word per channel from the accumulator stage and shifts all channels out simultaneously, one serial line per channel, starting on Frame. A shadow register lets the next result be loaded while the current word is still shifting, and back-to-back frames produce gap-free output. Overrun and underrun are flagged to the controller.

## Interface
Parameters:
- WIDTH, 40, bits per channel word (>= 2)
- NCH, 2, number of channels (1 = mono, 2 = L/R)
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 first

Ports:
- Sclk  in  1  clock; all logic on rising edge
- Clear  in  1  reset; synchronous, active-high
- p2s_en  in  1  load strobe; captures Shift_done into shadow register
- Frame  in  1  frame-start strobe from frame sync
- Shift_done  in  NCH*WIDTH  packed words; channel c = Shift_done[c*WIDTH +: WIDTH]
- SerialOut  out  NCH  serial data; bit c belongs to channel c
- OutReady  out  1  high while SerialOut carries valid bits
- BufFull  out  1  shadow register holds an unsent word
- Overrun  out  1  one-cycle pulse: load overwrote an unsent shadow word
- Underrun  out  1  one-cycle pulse: Frame accepted with an empty shadow

## Operation
- Storage:
  - shadow[NCH*WIDTH] with flag shadow_valid (drives BufFull)
  - shift[NCH*WIDTH]
  - bit counter cnt, width $clog2(WIDTH), holding the index of the bit currently driven (counting down WIDTH-1..0 regardless of MSB_FIRST)
- States: IDLE, SHIFT.
- Load: on p2s_en=1, shadow <= Shift_done and shadow_valid <= 1.
  - If shadow_valid was already 1 and the shadow is not consumed in the same cycle, Overrun pulses. Newest data wins.
- Start condition: Frame=1 with shadow_valid=1, either in IDLE or in SHIFT with cnt==0.
  - shift <= shadow; shadow_valid <= 0, unless p2s_en=1 in the same cycle, in which case shadow_valid stays 1 with the new data.
  - SerialOut[c] <= first bit of channel c (MSB if MSB_FIRST, else LSB); OutReady <= 1; cnt <= WIDTH-1; state <= SHIFT.
- SHIFT: each cycle, SerialOut[c] <= next bit of channel c and cnt decrements.
  - When cnt==0 and no start condition holds, the state returns to IDLE; SerialOut <= 0 and OutReady <= 0.
- Frame in SHIFT with cnt != 0 is ignored: no flag is raised and no state changes.
- Frame with shadow_valid=0 (in IDLE, or in SHIFT at cnt==0): Underrun pulses for one cycle. Outputs go to or stay at 0.
- Same-cycle p2s_en and Frame with an empty shadow: Frame sees the shadow as empty, so Underrun pulses. The load completes and BufFull rises the next cycle.
- Clear, including mid-word: state <= IDLE, all registers and outputs <= 0, shadow discarded. Clear has priority over every other input.

## Timing
- Reset values: SerialOut = 0, OutReady = 0, BufFull = 0, Overrun = 0, Underrun = 0.
- p2s_en to BufFull: 1 cycle.
- Frame to first valid bit: 1 cycle. The bit is registered at the edge that samples Frame.
- OutReady stays high for exactly WIDTH consecutive cycles per word.
- With Frame asserted at the cnt==0 edge, the next word follows with zero idle cycles and OutReady remains continuously high.
- Overrun and Underrun are registered and last one cycle each.
- Minimum load-to-Frame spacing: 1 cycle.

## Test plan
- WIDTH=40, NCH=2, MSB_FIRST=1: load L=40'h80_0000_0001, R=40'h00_0000_00FF, Frame 3 cycles later.
  - Expect OutReady high for 40 cycles.
  - L line: 1, then 38 zeros, then 1.
  - R line: 32 zeros, then 8 ones.
  - BufFull falls at the start edge.
- Back-to-back: load word A, Frame, load word B during shifting, Frame at the last bit of A.
  - Expect 80 contiguous OutReady cycles, B immediately after A, no flags.
- Two p2s_en strobes with no intervening Frame.
  - Expect Overrun pulse on the second load; the next Frame transmits the second word.
- Frame after Clear with no load.
  - Expect Underrun pulse; SerialOut = 0 and OutReady = 0 throughout.
  - Same result for same-cycle p2s_en and Frame on an empty shadow; BufFull = 1 afterwards.
- Clear asserted at bit 20 of a word with the shadow full.
  - Next cycle: all outputs 0 and BufFull = 0.
  - A subsequent Frame gives Underrun.
- MSB_FIRST=0, WIDTH=16, NCH=1: load 16'h0003.
  - Expect serial stream 1, 1, then 14 zeros.

Source files
------------

// File: rtl/msdap_piso_nch.sv
// Double-buffered parallel-to-serial converter for the MSDAP output path.
// It shifts all NCH channels out together, one serial line per channel.
module msdap_piso_nch #(
  parameter int WIDTH     = 40,
  parameter int NCH       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 Sclk,
  input  logic                 Clear,
  input  logic                 p2s_en,
  input  logic                 Frame,
  input  logic [NCH*WIDTH-1:0] Shift_done,
  output logic [NCH-1:0]       SerialOut,
  output logic                 OutReady,
  output logic                 BufFull,
  output logic                 Overrun,
  output logic                 Underrun
);

  // state | meaning
  // IDLE  | no word on the lines, SerialOut/OutReady low
  // SHIFT | a word is being shifted out, cnt_q = index of bit on the lines
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t               state_q;
  logic [NCH*WIDTH-1:0] shadow_q;
  logic                 shadow_valid_q;
  logic [NCH*WIDTH-1:0] shift_q;
  logic [CW-1:0]        cnt_q;
  logic [NCH-1:0]       serial_q;
  logic                 out_ready_q;
  logic                 overrun_q;
  logic                 underrun_q;

  logic                 frame_slot;
  logic                 start;
  logic                 underrun_d;
  logic                 overrun_d;
  logic [CW-1:0]        nxt_idx;
  logic [NCH-1:0]       first_bits;
  logic [NCH-1:0]       next_bits;

  always_comb begin
    frame_slot = Frame && ((state_q == IDLE) || (cnt_q == '0));
    start      = frame_slot && shadow_valid_q;
    underrun_d = frame_slot && !shadow_valid_q;
    overrun_d  = p2s_en && shadow_valid_q && !start;
    // cnt_q counts down in both orders; LSB-first maps it to WIDTH-cnt_q
    // (modulo arithmetic keeps this right for power-of-two WIDTH too).
    nxt_idx    = MSB_FIRST ? (cnt_q - CW'(1)) : (CW'(WIDTH) - cnt_q);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] shd_w;
    logic [WIDTH-1:0] shf_w;
    assign shd_w         = shadow_q[c*WIDTH +: WIDTH];
    assign shf_w         = shift_q[c*WIDTH +: WIDTH];
    assign first_bits[c] = MSB_FIRST ? shd_w[WIDTH-1] : shd_w[0];
    assign next_bits[c]  = shf_w[nxt_idx];
  end

  always_ff @(posedge Sclk) begin
    if (Clear) begin
      state_q        <= IDLE;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      shift_q        <= '0;
      cnt_q          <= '0;
      serial_q       <= '0;
      out_ready_q    <= 1'b0;
      overrun_q      <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;

      if (p2s_en) begin
        shadow_q       <= Shift_done;
        shadow_valid_q <= 1'b1;
      end else if (start) begin
        shadow_valid_q <= 1'b0;
      end

      if (start) begin
        shift_q     <= shadow_q;
        serial_q    <= first_bits;
        out_ready_q <= 1'b1;
        cnt_q       <= CW'(WIDTH - 1);
        state_q     <= SHIFT;
      end else if ((state_q == SHIFT) && (cnt_q != '0)) begin
        serial_q <= next_bits;
        cnt_q    <= cnt_q - CW'(1);
      end else begin
        state_q     <= IDLE;
        serial_q    <= '0;
        out_ready_q <= 1'b0;
      end
    end
  end

  assign SerialOut = serial_q;
  assign OutReady  = out_ready_q;
  assign BufFull   = shadow_valid_q;
  assign Overrun   = overrun_q;
  assign Underrun  = underrun_q;

endmodule

// File: tb/tb_msdap_piso_nch.sv
// Directed bench for msdap_piso_nch: a stereo MSB-first 40-bit instance
// and a mono LSB-first 16-bit instance share one clock.
module tb_msdap_piso_nch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, en, frm;
  logic [79:0] data;
  logic [1:0]  ser;
  logic        rdy, full, ovr, und;

  logic        clr2, en2, frm2;
  logic [15:0] data2;
  logic [0:0]  ser2;
  logic        rdy2, full2, ovr2, und2;

  int checks = 0;
  int failures = 0;

  msdap_piso_nch #(.WIDTH(40), .NCH(2), .MSB_FIRST(1'b1)) dut (
    .Sclk(clk), .Clear(clr), .p2s_en(en), .Frame(frm), .Shift_done(data),
    .SerialOut(ser), .OutReady(rdy), .BufFull(full), .Overrun(ovr), .Underrun(und)
  );

  msdap_piso_nch #(.WIDTH(16), .NCH(1), .MSB_FIRST(1'b0)) dut2 (
    .Sclk(clk), .Clear(clr2), .p2s_en(en2), .Frame(frm2), .Shift_done(data2),
    .SerialOut(ser2), .OutReady(rdy2), .BufFull(full2), .Overrun(ovr2), .Underrun(und2)
  );

  typedef struct {
    logic        clr, en, frm;
    logic [79:0] data;
    logic [1:0]  ser;
    logic        rdy, full, ovr, und;
  } vec_t;

  vec_t vecs [13];

  localparam logic [79:0] WX  = {40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF};
  localparam logic [79:0] WY  = {40'h00_0000_0000, 40'h80_0000_0000};
  localparam logic [79:0] WA  = {40'h00_0000_00FF, 40'h80_0000_0001};
  localparam logic [79:0] WL1 = {40'h00_0000_0000, 40'hFF_FFFF_FFFF};
  localparam logic [79:0] WR1 = {40'hFF_FFFF_FFFF, 40'h00_0000_0000};

  // Inputs change on the falling edge; outputs are sampled 1 ns after the
  // rising edge that captured them.
  task automatic step(input logic c, input logic e, input logic f, input logic [79:0] d);
    @(negedge clk);
    clr = c; en = e; frm = f; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic c, input logic e, input logic f, input logic [15:0] d);
    @(negedge clk);
    clr2 = c; en2 = e; frm2 = f; data2 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual={und,ovr,full,rdy,ser}=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_main(input string name, input logic [1:0] es, input logic er,
                          input logic ef, input logic eo, input logic eu);
    chk(name, {und, ovr, full, rdy, ser}, {eu, eo, ef, er, es});
  endtask

  task automatic chk_mono(input string name, input logic es, input logic er,
                          input logic ef, input logic eo, input logic eu);
    chk(name, {und2, ovr2, full2, rdy2, 1'b0, ser2[0]}, {eu, eo, ef, er, 1'b0, es});
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; frm = 1'b0; data = '0;
    clr2 = 1'b1; en2 = 1'b0; frm2 = 1'b0; data2 = '0;

    //          clr   en    frm   data  ser    rdy   full  ovr   und
    vecs[0]  = '{1'b1, 1'b1, 1'b1, WX, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, WX, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, WX, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, WX, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, WY, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, WX, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, WX, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, WX, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, WX, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, WY, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, WX, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, WX, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, WX, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

    step(1'b1, 1'b0, 1'b0, '0);
    chk_main("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].frm, vecs[i].data);
      chk_main($sformatf("vec%0d", i), vecs[i].ser, vecs[i].rdy, vecs[i].full,
               vecs[i].ovr, vecs[i].und);
    end

    // Single word, Frame three cycles after the load, then Frame on an empty shadow at cnt 0.
    step(1'b0, 1'b1, 1'b0, WA);
    chk_main("wordA_load", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, (k == 0), '0);
      chk_main($sformatf("wordA_bit%0d", k), {(k >= 32), (k == 0 || k == 39)},
               1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, '0);
    chk_main("wordA_end_underrun", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0);
    chk_main("wordA_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: B loaded at k=10, stray Frame at k=20, Frame at the cnt==0 edge.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, WL1);
    for (int k = 0; k < 80; k++) begin
      step(1'b0, (k == 10), (k == 0 || k == 20 || k == 40), (k == 10) ? WR1 : WX);
      chk_main($sformatf("b2b_k%0d", k), (k < 40) ? 2'b01 : 2'b10, 1'b1,
               (k >= 10 && k < 40), 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    chk_main("b2b_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clear at bit 20 with the shadow full, then Frame gives Underrun.
    step(1'b0, 1'b1, 1'b0, WL1);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b0, WR1);
    for (int k = 2; k < 20; k++) step(1'b0, 1'b0, 1'b0, '0);
    chk_main("clr_before", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk_main("clr_mid_word", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, '0);
    chk_main("clr_then_frame", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Mono LSB-first 16-bit instance.
    step2(1'b1, 1'b0, 1'b0, '0);
    chk_mono("mono_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step2(1'b0, 1'b1, 1'b0, 16'h0003);
    chk_mono("mono_load", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step2(1'b0, 1'b0, (k == 0), '0);
      chk_mono($sformatf("mono_bit%0d", k), (k < 2), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step2(1'b0, 1'b0, 1'b0, '0);
    chk_mono("mono_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
